// File: rtl/stream_ddot_acc.sv
// Streaming signed dot-product accumulator.
// Masked lane products, adder tree, saturating accumulate.
module stream_ddot_acc #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES-1:0]          in_mask,
  input  logic [LANES*DATA_W-1:0]   x,
  input  logic [LANES*DATA_W-1:0]   y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          z,
  output logic                      out_ovf,
  output logic [15:0]               beat_cnt
);

  localparam int PW = 2 * DATA_W;
  localparam logic [ACC_W-1:0] AMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AMIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic              rdy_q;
  logic              acc_en;
  logic              hs;
  logic              v1, last1;
  logic              v2, last2;
  logic              done3;
  logic signed [PW-1:0] pc [LANES];
  logic signed [PW-1:0] p1 [LANES];
  logic [ACC_W-1:0]  sum_c, sum2;
  logic [ACC_W-1:0]  acc, acc_nx;
  logic [ACC_W:0]    tot;
  logic              sat_hi, sat_lo;
  logic              ovf;
  logic [15:0]       cnt;

  assign acc_en    = in_valid && rdy_q;
  assign out_valid = (state_q == HOLD);
  assign hs        = out_valid && out_ready;
  assign in_ready  = rdy_q;
  assign z         = acc;
  assign out_ovf   = ovf;
  assign beat_cnt  = cnt;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      pc[i] = '0;
      if (in_mask[i])
        pc[i] = $signed(x[i*DATA_W +: DATA_W])
              * $signed(y[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++)
      sum_c = sum_c
            + {{(ACC_W-PW){p1[i][PW-1]}}, p1[i]};
  end

  // One extra bit exposes signed overflow of acc+sum.
  always_comb begin
    tot    = {acc[ACC_W-1], acc}
           + {sum2[ACC_W-1], sum2};
    sat_hi = (tot[ACC_W:ACC_W-1] == 2'b01);
    sat_lo = (tot[ACC_W:ACC_W-1] == 2'b10);
    acc_nx = tot[ACC_W-1:0];
    unique case (1'b1)
      sat_hi:  acc_nx = AMAX;
      sat_lo:  acc_nx = AMIN;
      default: acc_nx = tot[ACC_W-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (acc_en && in_last) state_d = DRAIN;
      DRAIN:   if (done3) state_d = HOLD;
      HOLD:    if (out_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      for (int i = 0; i < LANES; i++)
        p1[i] <= '0;
    end else begin
      v1    <= acc_en;
      last1 <= acc_en && in_last;
      if (acc_en)
        for (int i = 0; i < LANES; i++)
          p1[i] <= pc[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2    <= 1'b0;
      last2 <= 1'b0;
      sum2  <= '0;
    end else begin
      v2    <= v1;
      last2 <= last1;
      if (v1) sum2 <= sum_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      ovf   <= 1'b0;
      done3 <= 1'b0;
    end else begin
      done3 <= v2 && last2;
      if (hs) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (v2) begin
        acc <= acc_nx;
        if (sat_hi || sat_lo) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (hs)
      cnt <= '0;
    else if (acc_en && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

endmodule
